fft_stream_source: RTL

//  Transmit side of the pipelined-FFT sample interface. Accepts complex samples
//  on a valid/ready stream with a frame marker and emits the ce/sync/data

---
 rtl/fft_pkg.sv | 19 +
 rtl/fft_sfifo.sv | 70 +++++++
 rtl/fft_stream_source.sv | 112 +++++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// fft_pkg: shared definitions for the FFT sample-interface blocks.
//   cpx_t      packed {re,im} complex sample at the default component width
//   CKPCE_MAX  largest supported spacing between output strobes
//   lg_n()     frame length N from log2(N)
package fft_pkg;

  localparam int CKPCE_MAX = 3;
  localparam int CPX_W     = 16;

  typedef struct packed {
    logic signed [CPX_W-1:0] re;
    logic signed [CPX_W-1:0] im;
  } cpx_t;

  function automatic int lg_n(input int lgwidth);
    return 1 << lgwidth;
  endfunction

endpackage

// File: rtl/fft_sfifo.sv
// fft_sfifo: synchronous first-word-fall-through FIFO.
//   clk    in   clock, rising edge
//   reset  in   synchronous active-high reset
//   push   in   write wdata (ignored while full)
//   pop    in   advance read side (ignored while empty)
//   wdata  in   WIDTH-bit write word
//   rdata  out  word at the head of the queue, valid while !empty
//   full   out  registered full flag
//   empty  out  registered empty flag
// Pointers carry one extra wrap bit so full and empty are told apart by
// comparing the MSBs once the index bits match.
module fft_sfifo #(
  parameter int WIDTH   = 33,
  parameter int LGDEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int DEPTH = 1 << LGDEPTH;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [LGDEPTH:0] wptr;
  logic [LGDEPTH:0] rptr;
  logic [LGDEPTH:0] wptr_nxt;
  logic [LGDEPTH:0] rptr_nxt;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wptr_nxt = wptr;
    rptr_nxt = rptr;
    if (do_push) wptr_nxt = wptr + 1'b1;
    if (do_pop)  rptr_nxt = rptr + 1'b1;
  end

  // Flags are computed from the next pointers so they are registered yet
  // exact. full is held high during reset so the producer sees "not ready"
  // until the first clock after reset is released.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      full  <= 1'b1;
      empty <= 1'b1;
    end else begin
      wptr  <= wptr_nxt;
      rptr  <= rptr_nxt;
      full  <= (wptr_nxt[LGDEPTH] != rptr_nxt[LGDEPTH]) &&
               (wptr_nxt[LGDEPTH-1:0] == rptr_nxt[LGDEPTH-1:0]);
      empty <= (wptr_nxt == rptr_nxt);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[LGDEPTH-1:0]] <= wdata;
  end

  assign rdata = mem[rptr[LGDEPTH-1:0]];

endmodule

// File: rtl/fft_stream_source.sv
// fft_stream_source: turns a valid/ready complex-sample stream with a frame
// marker into the ce/sync/data stream consumed by the first FFT stage.
//   i_clk    in   clock, rising edge
//   i_reset  in   synchronous active-high reset
//   s_valid  in   input sample valid
//   s_ready  out  block can accept (registered)
//   s_data   in   {re,im} sample, 2*IWIDTH bits
//   s_last   in   marks sample N-1 of a frame
//   o_ce     out  one-clock strobe per emitted sample
//   o_sync   out  with o_ce on sample 0 of a frame
//   o_data   out  emitted sample, holds between strobes
//   o_err    out  one-clock pulse when s_last disagrees with frame position
// Frame position is tracked on the input side and stored with each sample,
// so frame alignment survives buffering and output pacing.
module fft_stream_source
  import fft_pkg::*;
#(
  parameter int IWIDTH  = 16,
  parameter int LGWIDTH = 9,
  parameter int LGFIFO  = 4,
  parameter int CKPCE   = 1
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [2*IWIDTH-1:0] s_data,
  input  logic                s_last,
  output logic                o_ce,
  output logic                o_sync,
  output logic [2*IWIDTH-1:0] o_data,
  output logic                o_err
);

  localparam int                 N         = lg_n(LGWIDTH);
  localparam int                 SW        = 2 * IWIDTH;
  localparam int                 PACE_W    = $clog2(CKPCE_MAX + 1);
  localparam logic [LGWIDTH-1:0] LAST_IDX  = LGWIDTH'(N - 1);
  localparam logic [PACE_W-1:0]  PACE_LOAD = PACE_W'(CKPCE - 1);

  logic [LGWIDTH-1:0] in_idx;
  logic [PACE_W-1:0]  pace;
  logic               fifo_full;
  logic               fifo_empty;
  logic               push_p0;
  logic               pop_p0;
  logic               frame_err_p0;
  logic [SW:0]        wr_entry_p0;
  logic [SW:0]        rd_entry_p0;
  logic               vld_p1;
  logic               sync_p1;
  logic               err_p1;
  logic [SW-1:0]      data_p1;

  // Stage p0: input handshake, frame check, FIFO, pop decision
  assign s_ready      = !fifo_full;
  assign push_p0      = s_valid && s_ready;
  assign wr_entry_p0  = {in_idx == '0, s_data};
  // Error whenever the marker and the expected end-of-frame position differ:
  // early s_last, or a missing s_last on index N-1.
  assign frame_err_p0 = push_p0 && (s_last != (in_idx == LAST_IDX));
  assign pop_p0       = !fifo_empty && (pace == '0);

  fft_sfifo #(
    .WIDTH  (SW + 1),
    .LGDEPTH(LGFIFO)
  ) u_fifo (
    .clk  (i_clk),
    .reset(i_reset),
    .push (push_p0),
    .pop  (pop_p0),
    .wdata(wr_entry_p0),
    .rdata(rd_entry_p0),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  // Stage p1: registered output strobe, sync, error and data
  // A marker always restarts the frame; a missing marker on N-1 restarts it
  // through the natural wrap of in_idx. The sample itself is always kept.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      in_idx  <= '0;
      pace    <= '0;
      vld_p1  <= 1'b0;
      sync_p1 <= 1'b0;
      err_p1  <= 1'b0;
    end else begin
      if (push_p0) in_idx <= s_last ? '0 : in_idx + 1'b1;
      if (pop_p0)
        pace <= PACE_LOAD;
      else if (pace != '0)
        pace <= pace - 1'b1;
      vld_p1  <= pop_p0;
      sync_p1 <= pop_p0 && rd_entry_p0[SW];
      err_p1  <= frame_err_p0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset)
      data_p1 <= '0;
    else if (pop_p0)
      data_p1 <= rd_entry_p0[SW-1:0];
  end

  assign o_ce   = vld_p1;
  assign o_sync = sync_p1;
  assign o_data = data_p1;
  assign o_err  = err_p1;

endmodule
